// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Drives open-drain clock/data through pull-low enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_DRIVE_LOW,
  output logic       PS2_DATA_DRIVE_LOW
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SEND,
    S_ACK,
    S_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_fe;

  state_t          r_state, w_state_n;
  logic [7:0]      r_shift, w_shift_n;
  logic            r_parity, w_parity_n;
  logic [IW-1:0]   r_inh, w_inh_n;
  logic [3:0]      r_bit, w_bit_n;
  logic [TW-1:0]   r_to, w_to_n;
  logic            r_clk_low, w_clk_low_n;
  logic            r_data_low, w_data_low_n;
  logic            r_err, w_err_n;
  logic            r_done, w_done_n;
  logic            w_active;
  logic            w_ready;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fe     = r_clk_prev & ~w_clk_s;

  // Pin synchronisers and falling-edge history, idle-high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], PS2_CLK_IN};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], PS2_DATA_IN};
      r_clk_prev  <= w_clk_s;
    end
  end

  // Transfer state and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_inh      <= '0;
      r_bit      <= '0;
      r_to       <= '0;
      r_clk_low  <= 1'b0;
      r_data_low <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_shift    <= w_shift_n;
      r_parity   <= w_parity_n;
      r_inh      <= w_inh_n;
      r_bit      <= w_bit_n;
      r_to       <= w_to_n;
      r_clk_low  <= w_clk_low_n;
      r_data_low <= w_data_low_n;
      r_err      <= w_err_n;
      r_done     <= w_done_n;
    end
  end

  assign w_ready  = (r_state == S_IDLE) && !r_done;
  assign w_active = (r_state == S_SEND) ||
                    (r_state == S_ACK)  ||
                    (r_state == S_WAIT);

  // Next-state logic; the watchdog overrides the frame sequencing.
  always_comb begin
    w_state_n    = r_state;
    w_shift_n    = r_shift;
    w_parity_n   = r_parity;
    w_inh_n      = r_inh;
    w_bit_n      = r_bit;
    w_to_n       = r_to;
    w_clk_low_n  = r_clk_low;
    w_data_low_n = r_data_low;
    w_err_n      = r_err;
    w_done_n     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (tx_valid && w_ready) begin
          w_shift_n   = tx_data;
          w_parity_n  = ~^tx_data;
          w_inh_n     = '0;
          w_err_n     = 1'b0;
          w_clk_low_n = 1'b1;
          w_state_n   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_inh == IW'(INHIBIT_CYCLES - 1)) begin
          w_clk_low_n  = 1'b0;
          w_data_low_n = 1'b1;
          w_bit_n      = '0;
          w_to_n       = '0;
          w_state_n    = S_SEND;
        end else begin
          w_inh_n = r_inh + IW'(1);
        end
      end
      S_SEND: begin
        if (w_fe) begin
          unique case (1'b1)
            (r_bit < 4'd8):  w_data_low_n = ~r_shift[r_bit[2:0]];
            (r_bit == 4'd8): w_data_low_n = ~r_parity;
            default:         w_data_low_n = 1'b0;
          endcase
          w_bit_n = r_bit + 4'd1;
          if (r_bit == 4'd9) w_state_n = S_ACK;
        end
      end
      S_ACK: begin
        if (w_fe) begin
          w_err_n   = w_data_s;
          w_state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_clk_s && w_data_s) begin
          w_done_n  = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_active) begin
      if (w_fe) begin
        w_to_n = '0;
      end else if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
        w_clk_low_n  = 1'b0;
        w_data_low_n = 1'b0;
        w_done_n     = 1'b1;
        w_err_n      = 1'b1;
        w_state_n    = S_IDLE;
      end else begin
        w_to_n = r_to + TW'(1);
      end
    end
  end

  assign tx_ready           = w_ready;
  assign busy               = (r_state != S_IDLE);
  assign tx_done            = r_done;
  assign tx_error           = r_done & r_err;
  assign PS2_CLK_DRIVE_LOW  = r_clk_low;
  assign PS2_DATA_DRIVE_LOW = r_data_low;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed + random frames against
// a PS/2 device model on open-drain lines.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       clk_dl, data_dl;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  wire        ps2_clk  = ~(clk_dl | dev_clk_low);
  wire        ps2_data = ~(data_dl | dev_data_low);

  int checks = 0;
  int errors = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(10),
    .TIMEOUT_CYCLES(200),
    .SYNC_STAGES(2)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .busy(busy),
    .PS2_CLK_IN(ps2_clk),
    .PS2_DATA_IN(ps2_data),
    .PS2_CLK_DRIVE_LOW(clk_dl),
    .PS2_DATA_DRIVE_LOW(data_dl)
  );

  always #5 clk = ~clk;

  // Line and handshake monitor, sampled on the falling CLK edge.
  int   cyc = 0, run = 0, last_run = 0;
  int   rel_cnt = 0, rel_cyc = 0, done_cnt = 0, done_cyc = 0;
  logic rel_data = 0, d_err = 0, d_busy = 0, d_pbusy = 0;
  logic d_cl = 0, d_dl = 0, ready_after = 0;
  logic p_done = 0, p_busy = 0;
  always @(negedge clk) begin
    cyc++;
    if (clk_dl) run++;
    else if (run > 0) begin
      last_run = run;
      run = 0;
      rel_cyc = cyc;
      rel_data = data_dl;
      rel_cnt++;
    end
    if (tx_done) begin
      done_cnt++;
      done_cyc = cyc;
      d_err = tx_error;
      d_busy = busy;
      d_pbusy = p_busy;
      d_cl = clk_dl;
      d_dl = data_dl;
    end
    if (p_done) ready_after = tx_ready;
    p_done = tx_done;
    p_busy = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Reference frame: start, LSB-first data, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9] = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send_req(input logic [7:0] b);
    int k;
    k = 0;
    while (!tx_ready && k < 100) begin
      tick(1);
      k++;
    end
    tx_data = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_release(input int r0, input string tag);
    int k;
    k = 0;
    while (rel_cnt <= r0 && k < 100) begin
      tick(1);
      k++;
    end
    chk({tag, "_rel_seen"}, 32'(rel_cnt > r0), 32'd1);
  endtask

  task automatic wait_done(input int d0, input string tag);
    int k;
    k = 0;
    while (done_cnt <= d0 && k < 400) begin
      tick(1);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt > d0), 32'd1);
  endtask

  // Device: 40-cycle clock, samples data before each falling edge.
  task automatic dev_run(input int np, input bit ack,
                         output logic [10:0] bits);
    bits = '0;
    tick(10);
    for (int i = 0; i < np; i++) begin
      tick(20);
      bits[i] = ps2_data;
      if (ack && i == 10) begin
        dev_data_low = 1'b1;
        tick(5);
      end
      dev_clk_low = 1'b1;
      tick(20);
      dev_clk_low = 1'b0;
    end
    if (ack && np == 11) begin
      tick(5);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [7:0] b, input bit ack,
                          input string tag);
    int r0, d0;
    logic [10:0] bits;
    r0 = rel_cnt;
    send_req(b);
    wait_release(r0, tag);
    chk({tag, "_inh_len"}, 32'(last_run), 32'd10);
    chk({tag, "_start_drv"}, 32'(rel_data), 32'd1);
    d0 = done_cnt;
    dev_run(11, ack, bits);
    chk({tag, "_frame"}, 32'(bits), 32'(frame_of(b)));
    wait_done(d0, tag);
    chk({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_err"}, 32'(d_err), 32'(!ack));
    chk({tag, "_busy_fall"}, 32'({d_pbusy, d_busy}), 32'b10);
    chk({tag, "_lines"}, 32'({d_cl, d_dl}), 32'b00);
    tick(2);
    chk({tag, "_ready"}, 32'(ready_after), 32'd1);
  endtask

  initial begin
    int r0, d0;
    logic [10:0] bits;
    logic [7:0] rb;
    bit ra;

    tick(4);
    chk("rst_outs",
        32'({tx_ready, busy, tx_done, tx_error, clk_dl, data_dl}),
        32'b100000);
    rst = 1'b0;
    tick(2);
    chk("idle_outs", 32'({tx_ready, busy}), 32'b10);

    do_frame(8'hED, 1'b1, "ed");
    do_frame(8'h00, 1'b1, "zero");
    do_frame(8'hFF, 1'b0, "noack");

    // Device never clocks after inhibit.
    r0 = rel_cnt;
    d0 = done_cnt;
    send_req(8'hF4);
    wait_release(r0, "to");
    wait_done(d0, "to");
    chk("to_delay", 32'(done_cyc - rel_cyc), 32'd200);
    chk("to_err", 32'(d_err), 32'd1);
    chk("to_lines", 32'({d_cl, d_dl, d_busy}), 32'b000);
    tick(2);
    chk("to_ready", 32'(ready_after), 32'd1);

    // Reset in the middle of a frame.
    r0 = rel_cnt;
    send_req(8'hF3);
    wait_release(r0, "rst");
    dev_run(5, 1'b0, bits);
    d0 = done_cnt;
    rst = 1'b1;
    tick(1);
    chk("rst_mid",
        32'({clk_dl, data_dl, busy, tx_ready}), 32'b0001);
    rst = 1'b0;
    tick(20);
    chk("rst_nodone", 32'(done_cnt), 32'(d0));
    do_frame(8'h55, 1'b1, "post_rst");

    // tx_valid held high across two frames.
    r0 = rel_cnt;
    d0 = done_cnt;
    tx_data = 8'h20;
    tx_valid = 1'b1;
    wait_release(r0, "b2b1");
    tx_data = 8'h21;
    dev_run(11, 1'b1, bits);
    chk("b2b1_frame", 32'(bits), 32'(frame_of(8'h20)));
    wait_done(d0, "b2b1");
    wait_release(r0 + 1, "b2b2");
    tx_valid = 1'b0;
    chk("b2b2_inh_len", 32'(last_run), 32'd10);
    dev_run(11, 1'b1, bits);
    chk("b2b2_frame", 32'(bits), 32'(frame_of(8'h21)));
    wait_done(d0 + 1, "b2b2");
    tick(60);
    chk("b2b_count", 32'(done_cnt - d0), 32'd2);
    chk("b2b_idle", 32'({busy, tx_ready}), 32'b01);

    // Random bytes with random ACK behaviour.
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      ra = 1'($urandom_range(0, 1));
      do_frame(rb, ra, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the send side of the keyboard port.
- Carries command bytes from the CPU to the keyboard: LED set 0xED, reset 0xFF, typematic 0xF3, and similar.
- Drives open-drain PS2 clock/data lines through active-high "pull low" enables.
- Shares the physical pins with the existing PS/2 receive path.
- Reports completion, keyboard ACK status, or timeout to the CPU-side I/O register.

Parameters:
- INHIBIT_CYCLES, 5000: CLK cycles the host holds PS2 clock low before the start bit (≥100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum CLK cycles allowed with no PS2 clock falling edge while the transfer is in progress (15 ms at 50 MHz).
- SYNC_STAGES, 2: synchroniser depth on PS2_CLK_IN and PS2_DATA_IN; must be ≥2.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- tx_data  in  8  command byte to send
- tx_valid  in  1  request; a byte is accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- tx_done  out  1  one-cycle pulse at the end of every transfer
- tx_error  out  1  valid while tx_done=1; 1 = no ACK or timeout
- busy  out  1  high in every state except IDLE
- PS2_CLK_IN  in  1  raw PS2 clock pin level
- PS2_DATA_IN  in  1  raw PS2 data pin level
- PS2_CLK_DRIVE_LOW  out  1  1 = pull PS2 clock low; 0 = release (pull-up)
- PS2_DATA_DRIVE_LOW  out  1  1 = pull PS2 data low; 0 = release

Behaviour:
- Reset:
  - State IDLE; all counters 0; synchroniser flops and the edge-detect flop set to 1.
  - tx_ready=1 (IDLE); busy=0; tx_done=0; tx_error=0; both DRIVE_LOW=0.
  - RST mid-transfer aborts immediately, releases both lines, and emits no tx_done.
- Input conditioning:
  - Inputs pass through SYNC_STAGES flops.
  - A falling edge ("fe") is a one-cycle strobe: previous synced clock=1 and current=0.
  - All state actions below occur on the CLK edge where fe is seen.
- Acceptance:
  - In IDLE, tx_valid=1 latches tx_data into a shift register.
  - Parity latched = ~^tx_data (odd parity).
  - Next state INHIBIT. tx_valid outside IDLE is ignored.
- INHIBIT:
  - PS2_CLK_DRIVE_LOW=1 for exactly INHIBIT_CYCLES cycles.
  - On the last cycle, PS2_DATA_DRIVE_LOW is set to 1 (start bit) in the same update that clears PS2_CLK_DRIVE_LOW to 0.
  - Next state SEND.
- SEND:
  - Bit counter n runs 0..9; the timeout counter is active.
  - Each fe: n=0..7 drives data bit n (LSB first); n=8 drives parity; n=9 releases data (stop bit). DRIVE_LOW = ~bit.
  - n increments on each fe; after n=9, next state ACK.
- ACK:
  - On the next fe, sample synced data: 0 = ACK (error=0), 1 = no ACK (error=1).
  - Next state WAIT_IDLE.
- WAIT_IDLE:
  - Wait until synced clock=1 and synced data=1.
  - Then pulse tx_done for one cycle with tx_error set, and return to IDLE.
- Timeout:
  - Counter clears on every fe and on entry to SEND. Runs in SEND, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES releases both lines and pulses tx_done=1 with tx_error=1 in that cycle.
  - Returns to IDLE.
- Line-drive invariant: the host never drives PS2 clock low outside INHIBIT.
- Receive-path interaction:
  - The receive path ignores frames while busy=1; the keyboard's 0xFA response byte arrives after tx_done.
  - tx_ready returns high the cycle after tx_done; back-to-back sends are allowed.

Test Plan (INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200, device model with PS2 clock period 40 CLK, ACK enabled unless stated):
- Send 0xED:
  - PS2_CLK_DRIVE_LOW high for exactly 10 cycles; data driven low at clock release.
  - Device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Device ACKs; one tx_done pulse with tx_error=0.
- Send 0x00:
  - Parity bit = 1; data lines low for all 8 data bits.
  - tx_done with tx_error=0; busy falls in the same cycle tx_done rises.
- Device omits ACK (data stays high on the 11th falling edge) for 0xFF:
  - tx_done with tx_error=1; both DRIVE_LOW=0.
- Device never clocks after inhibit:
  - 200 cycles after clock release, tx_done=1 with tx_error=1; state IDLE; tx_ready=1.
- Assert RST after 4 data bits of 0xF3:
  - Next cycle both DRIVE_LOW=0, busy=0, tx_ready=1; no tx_done pulse.
  - New request 0x55 completes correctly.
- Hold tx_valid continuously with 0x20 then 0x21:
  - Two complete frames, each with inhibit; tx_valid during busy has no effect.
  - Exactly two tx_done pulses.
